mux_32_bit_2x1: RTL and testbench
=================================

MUX_32_BIT_2X1 -- requirements
Module: mux_32_bit_2x1

Interface
- REQ-001: Parameter RST_VAL, default 32'h0000_0000; value loaded into the registered outputs on reset.
- REQ-002: Parameter REG_OUT_EN, default 1; when 1, the registered outputs are updated every cycle; when 0, they hold RST_VAL.
- REQ-003: Port clk, input, 1 bit; single clock, rising-edge active.
- REQ-004: Port rst, input, 1 bit; reset is synchronous and active-high.
- REQ-005: Port in_data1, input, 32 bits; data source selected when control=0.
- REQ-006: Port in_data2, input, 32 bits; data source selected when control=1.
- REQ-007: Port control, input, 1 bit; select line.
- REQ-008: Port out_data, output, 32 bits; combinational mux result.
- REQ-009: Port out_data_q, output, 32 bits; out_data registered by one clk.
- REQ-010: Port out_sel_q, output, 1 bit; control registered by one clk, aligned with out_data_q.
- REQ-011: Port out_parity_q, output, 1 bit; exists only when MUX_32_BIT_2X1_PARITY_EN is defined.

Function
- REQ-012: out_data SHALL equal in_data1 when control=0 and in_data2 when control=1, with zero-cycle latency and no dependence on clk or rst.
- REQ-013: When control is X/Z, out_data SHALL be all-X in simulation; synthesis treats it as don't-care.
- REQ-014: On each rising clk edge with rst=0 and REG_OUT_EN=1, out_data_q SHALL take the current out_data and out_sel_q SHALL take the current control (latency: 1 cycle).
- REQ-015: Changes on inputs between clock edges SHALL affect out_data immediately and the registered outputs only at the next rising edge.
- REQ-016: Simultaneous changes of control and both data inputs SHALL produce the mux result for the new values; glitch-free behaviour is not required.
- REQ-017: Selection SHALL be bit-exact across all 32 bits, with no width extension or truncation.

Reset
- REQ-018: While rst=1 at a rising clk edge, out_data_q SHALL become RST_VAL, out_sel_q SHALL become 0, and out_parity_q (if present) SHALL become the even parity of RST_VAL.
- REQ-019: Reset SHALL NOT affect out_data.
- REQ-020: An assertion of rst mid-operation SHALL override the register update in that same cycle.
- REQ-021: The first post-reset edge SHALL capture normally.

Configuration
- REQ-022: When the macro MUX_32_BIT_2X1_PARITY_EN is defined, out_parity_q SHALL be a register holding the XOR-reduction of out_data, with the same update and reset rules as out_data_q.
- REQ-023: When MUX_32_BIT_2X1_PARITY_EN is undefined, out_parity_q and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
- REQ-024: The package mux_32_bit_2x1_pkg SHALL hold DATA_W=32 and the select constants SEL_IN1=1'b0 and SEL_IN2=1'b1.
- REQ-025: The output register stage SHALL be one sub-module, mux_out_reg, which is a DATA_W-bit register with synchronous reset and an RST_VAL parameter.
- REQ-026: The mux itself SHALL be pure combinational logic in the top module.

Verification
- REQ-027: Scenario: in_data1=0, in_data2=0, control=0, and rst held for 2 clocks -> out_data=0, out_data_q=0, out_sel_q=0.
- REQ-028: Scenario: control=0, in_data1=32'hB5B5B5B5, in_data2=32'h6C6C6C6C -> out_data=32'hB5B5B5B5 immediately; out_data_q=32'hB5B5B5B5 after the next edge.
- REQ-029: Scenario: control=1, in_data1=32'hE6E6E6E6, in_data2=32'h7E7E7E7E -> out_data=32'h7E7E7E7E; out_sel_q=1 and out_data_q=32'h7E7E7E7E one edge later.
- REQ-030: Scenario: control toggles 0->1->0 on consecutive cycles with fixed data -> out_data_q alternates between in_data1 and in_data2 with exactly one cycle of lag.
- REQ-031: Scenario: rst=1 asserted in the same cycle that control changes -> registered outputs are RST_VAL/0 and out_data still follows control.
- REQ-032: Scenario (parity enabled): selected data 32'h7E7E7E7E -> out_parity_q=0 after one edge; selected data 32'h00000001 -> out_parity_q=1 after one edge.

Source files
------------

// File: rtl/mux_32_bit_2x1_pkg.sv
// -----------------------------------------------------------------------------
// mux_32_bit_2x1_pkg
//   Shared constants for the 32-bit 2:1 mux block.
//   DATA_W  : datapath width of both sources and the result.
//   SEL_IN1 : control value that selects in_data1.
//   SEL_IN2 : control value that selects in_data2.
//   even_parity() : XOR-reduction of a data word; a 1 means the word holds an
//                   odd number of ones, so word plus bit has even weight.
// -----------------------------------------------------------------------------
package mux_32_bit_2x1_pkg;

    localparam int   DATA_W  = 32;
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    function automatic logic even_parity(input logic [DATA_W-1:0] value);
        return ^value;
    endfunction

endpackage : mux_32_bit_2x1_pkg

// File: rtl/mux_out_reg.sv
// -----------------------------------------------------------------------------
// mux_out_reg
//   Output register stage for the mux block. Plain WIDTH-bit register with a
//   synchronous, active-high reset to RST_VAL.
//
//   Parameters
//     WIDTH   : register width (defaults to DATA_W).
//     RST_VAL : value loaded while rst=1 at a rising clk edge.
//     EN      : 1 -> capture d on every edge; 0 -> register is parked at
//               RST_VAL permanently (reset and run look identical).
//
//   Ports
//     clk : rising-edge clock.
//     rst : synchronous active-high reset; wins over the capture.
//     d   : value to capture.
//     q   : registered value, one clk after d.
// -----------------------------------------------------------------------------
module mux_out_reg
    import mux_32_bit_2x1_pkg::*;
#(
    parameter int               WIDTH   = DATA_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               EN      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // With the stage disabled the register keeps reloading RST_VAL, so the
    // output never moves away from its reset value.
    always_comb begin
        data_d = RST_VAL;
        if (EN) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : mux_out_reg

// File: rtl/mux_32_bit_2x1.sv
// -----------------------------------------------------------------------------
// mux_32_bit_2x1
//   32-bit 2:1 multiplexer with a combinational result and a one-cycle
//   registered copy of the result and of the select line.
//
//   Parameters
//     RST_VAL    : value loaded into out_data_q on reset (default 0).
//     REG_OUT_EN : 1 -> registered outputs update every cycle;
//                  0 -> registered outputs hold their reset values.
//
//   Ports
//     clk          : rising-edge clock.
//     rst          : synchronous active-high reset (registered outputs only).
//     in_data1     : source selected when control = SEL_IN1 (0).
//     in_data2     : source selected when control = SEL_IN2 (1).
//     control      : select line.
//     out_data     : combinational mux result, independent of clk/rst.
//     out_data_q   : out_data registered by one clk.
//     out_sel_q    : control registered by one clk, aligned with out_data_q.
//     out_parity_q : XOR-reduction of out_data, registered by one clk.
//                    Present only when MUX_32_BIT_2X1_PARITY_EN is defined.
//
//   Build option
//     MUX_32_BIT_2X1_PARITY_EN : adds the out_parity_q port and its register.
// -----------------------------------------------------------------------------
module mux_32_bit_2x1
    import mux_32_bit_2x1_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_VAL    = 32'h0000_0000,
    parameter bit                REG_OUT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic              control,
    output logic [DATA_W-1:0] out_data,
`ifdef MUX_32_BIT_2X1_PARITY_EN
    output logic              out_parity_q,
`endif
    output logic [DATA_W-1:0] out_data_q,
    output logic              out_sel_q
);

    logic [DATA_W-1:0] mux_d;

    // An unknown select falls through to the default arm, so simulation
    // shows an all-X result instead of a bitwise merge of the two sources;
    // synthesis is free to treat that arm as don't-care.
    always_comb begin
        mux_d = 'x;
        case (control)
            SEL_IN1: mux_d = in_data1;
            SEL_IN2: mux_d = in_data2;
            default: mux_d = 'x;
        endcase
    end

    assign out_data = mux_d;

    // Data register.
    mux_out_reg #(
        .WIDTH   (DATA_W),
        .RST_VAL (RST_VAL),
        .EN      (REG_OUT_EN)
    ) u_data_reg (
        .clk (clk),
        .rst (rst),
        .d   (mux_d),
        .q   (out_data_q)
    );

    // Select register; resets to 0 so it reads as "in_data1" after reset.
    mux_out_reg #(
        .WIDTH   (1),
        .RST_VAL (1'b0),
        .EN      (REG_OUT_EN)
    ) u_sel_reg (
        .clk (clk),
        .rst (rst),
        .d   (control),
        .q   (out_sel_q)
    );

`ifdef MUX_32_BIT_2X1_PARITY_EN
    logic parity_d;

    // Parity is taken from the mux result (not the registered data) so it
    // lands in the same cycle as out_data_q. Its reset value is the parity
    // of RST_VAL, keeping the pair self-consistent while in reset.
    always_comb begin
        parity_d = even_parity(mux_d);
    end

    mux_out_reg #(
        .WIDTH   (1),
        .RST_VAL (^RST_VAL),
        .EN      (REG_OUT_EN)
    ) u_parity_reg (
        .clk (clk),
        .rst (rst),
        .d   (parity_d),
        .q   (out_parity_q)
    );
`endif

endmodule : mux_32_bit_2x1

// File: tb/tb_mux_32_bit_2x1.sv
// -----------------------------------------------------------------------------
// tb_mux_32_bit_2x1
//   Directed and randomised checks for mux_32_bit_2x1. Instance u_dut uses
//   default parameters; u_dut_b uses a non-zero RST_VAL with REG_OUT_EN=0 and
//   shares the same inputs. Registered expectations are packed as
//   {parity, sel, data} in exp_q.
// -----------------------------------------------------------------------------
module tb_mux_32_bit_2x1;

    localparam logic [31:0] B_RST = 32'hDEAD_BEEF;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data1 = '0;
    logic [31:0] in_data2 = '0;
    logic        control = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] out_data, out_data_q;
    logic        out_sel_q;
    logic [31:0] b_out_data, b_out_data_q;
    logic        b_out_sel_q;
`ifdef MUX_32_BIT_2X1_PARITY_EN
    logic        out_parity_q;
    logic        b_out_parity_q;
`endif

    mux_32_bit_2x1 u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_data1     (in_data1),
        .in_data2     (in_data2),
        .control      (control),
        .out_data     (out_data),
`ifdef MUX_32_BIT_2X1_PARITY_EN
        .out_parity_q (out_parity_q),
`endif
        .out_data_q   (out_data_q),
        .out_sel_q    (out_sel_q)
    );

    mux_32_bit_2x1 #(
        .RST_VAL    (B_RST),
        .REG_OUT_EN (1'b0)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_data1     (in_data1),
        .in_data2     (in_data2),
        .control      (control),
        .out_data     (b_out_data),
`ifdef MUX_32_BIT_2X1_PARITY_EN
        .out_parity_q (b_out_parity_q),
`endif
        .out_data_q   (b_out_data_q),
        .out_sel_q    (b_out_sel_q)
    );

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    logic [33:0] last_exp = '0;
    bit          have_last = 1'b0;
    int          passed = 0;
    int          total  = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Reference mux and expected register word.
    function automatic logic [31:0] ref_mux(input logic c, input logic [31:0] d1, input logic [31:0] d2);
        return c ? d2 : d1;
    endfunction

    function automatic logic [33:0] ref_reg(input logic r, input logic c, input logic [31:0] d1,
                                            input logic [31:0] d2);
        logic [31:0] m;
        m = ref_mux(c, d1, d2);
        if (r) return {1'b0, 1'b0, 32'h0};
        return {^m, c, m};
    endfunction

    // ---------------- driver tasks ----------------
    // Drive inputs, then check the combinational result right away and check
    // that the registered outputs have not moved yet.
    task automatic drive_and_check(input logic r, input logic c, input logic [31:0] d1,
                                   input logic [31:0] d2);
        rst      = r;
        control  = c;
        in_data1 = d1;
        in_data2 = d2;
        #1;
        check32("out_data", out_data, ref_mux(c, d1, d2));
        check32("b_out_data", b_out_data, ref_mux(c, d1, d2));
        if (have_last) begin
            check32("hold_data_q", out_data_q, last_exp[31:0]);
            check1("hold_sel_q", out_sel_q, last_exp[32]);
        end
    endtask

    task automatic capture();
        logic [33:0] got;
        @(posedge clk);
        #1;
        total++;
        assert (exp_q.size() > 0) passed++;
        else $error("FAIL exp_q_empty observed=0 expected=1");
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check32("out_data_q", out_data_q, got[31:0]);
            check1("out_sel_q", out_sel_q, got[32]);
`ifdef MUX_32_BIT_2X1_PARITY_EN
            check1("out_parity_q", out_parity_q, got[33]);
            check1("b_out_parity_q", b_out_parity_q, ^B_RST);
`endif
            check32("b_out_data_q", b_out_data_q, B_RST);
            check1("b_out_sel_q", b_out_sel_q, 1'b0);
            last_exp  = got;
            have_last = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        drive_and_check(r, c, d1, d2);
        exp_q.push_back(ref_reg(r, c, d1, d2));
        capture();
    endtask

    // Two input sets inside one cycle: only the later one may be captured.
    task automatic step_change(input logic c_a, input logic [31:0] d1_a, input logic [31:0] d2_a,
                               input logic c_b, input logic [31:0] d1_b, input logic [31:0] d2_b);
        @(negedge clk);
        drive_and_check(1'b0, c_a, d1_a, d2_a);
        #1;
        drive_and_check(1'b0, c_b, d1_b, d2_b);
        exp_q.push_back(ref_reg(1'b0, c_b, d1_b, d2_b));
        capture();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held for two clocks with all-zero inputs.
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0);

        // First post-reset capture plus basic selection.
        step(1'b0, 1'b0, 32'hB5B5_B5B5, 32'h6C6C_6C6C);
        step(1'b0, 1'b1, 32'hE6E6_E6E6, 32'h7E7E_7E7E);

        // Control toggling with fixed data.
        step(1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        step(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222);
        step(1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);

        // Reset in the same cycle that control changes, then recovery.
        step(1'b0, 1'b0, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        step(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        step(1'b0, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);

        // Parity corner words and full-width boundaries.
        step(1'b0, 1'b1, 32'h0000_0000, 32'h7E7E_7E7E);
        step(1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'h8000_0000, 32'h0000_0001);

        // Mid-cycle changes, including all inputs switching together.
        step_change(1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0);
        step_change(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 32'h0000_0003, 32'h8000_0000);

        // Randomised tail with occasional reset.
        for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_mux_32_bit_2x1
